// File: rtl/snitch_fpu_wb.sv
// FPU/LSU writeback: FP regfile write port, integer response, scoreboard, fflags.
// SNITCH_FPU_WB_BYPASS_EN mirrors the regfile write onto the fwd_* bypass.
module snitch_fpu_wb #(
  parameter int unsigned FLEN      = 64,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NumFpRegs = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  input  logic                 fpu_valid_i,
  output logic                 fpu_ready_o,
  input  logic [FLEN-1:0]      fpu_result_i,
  input  logic [4:0]           fpu_status_i,
  input  logic [5:0]           fpu_tag_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_rd_i,
  input  logic [FLEN-1:0]      lsu_data_i,
  output logic                 fpr_we_o,
  output logic [4:0]           fpr_waddr_o,
  output logic [FLEN-1:0]      fpr_wdata_o,
  output logic                 acc_resp_valid_o,
  input  logic                 acc_resp_ready_i,
  output logic [4:0]           acc_resp_id_o,
  output logic [XLEN-1:0]      acc_resp_data_o,
  input  logic                 fflags_we_i,
  input  logic [4:0]           fflags_wdata_i,
  output logic [4:0]           fflags_o,
  output logic [NumFpRegs-1:0] pending_o,
  output logic                 fwd_valid_o,
  output logic [4:0]           fwd_addr_o,
  output logic [FLEN-1:0]      fwd_data_o
);

  logic                 fpu_int;
  logic                 fpu_fp_req;
  logic                 conflict;
  logic                 resp_free;
  logic                 fpu_hs;
  logic                 lsu_hs;
  logic                 fpu_wr;
  logic                 prio_q;
  logic                 we_q;
  logic [4:0]           waddr_q;
  logic [FLEN-1:0]      wdata_q;
  logic                 rv_q;
  logic [4:0]           rid_q;
  logic [XLEN-1:0]      rdata_q;
  logic [4:0]           fflags_q;
  logic [4:0]           fflags_d;
  logic [NumFpRegs-1:0] pending_q;
  logic [NumFpRegs-1:0] pend_set;
  logic [NumFpRegs-1:0] pend_clr;

  assign fpu_int    = fpu_tag_i[5];
  assign fpu_fp_req = fpu_valid_i && !fpu_int;
  assign conflict   = fpu_fp_req && lsu_valid_i;
  assign resp_free  = !rv_q || acc_resp_ready_i;

  // Readies are held low in reset so nothing is acknowledged and then lost.
  always_comb begin
    fpu_ready_o = 1'b0;
    lsu_ready_o = 1'b0;
    if (rst_ni) begin
      fpu_ready_o = fpu_int ? resp_free : (!conflict || prio_q);
      lsu_ready_o = !(conflict && prio_q);
    end
  end

  assign fpu_hs = fpu_valid_i && fpu_ready_o;
  assign lsu_hs = lsu_valid_i && lsu_ready_o;
  assign fpu_wr = fpu_hs && !fpu_int;

  assign pend_set = issue_valid_i ? (NumFpRegs'(1) << issue_rd_i) : '0;
  assign pend_clr = we_q ? (NumFpRegs'(1) << waddr_q) : '0;

  always_comb begin
    fflags_d = fflags_we_i ? fflags_wdata_i : fflags_q;
    if (fpu_hs) fflags_d = fflags_d | fpu_status_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q    <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rv_q      <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      fflags_q  <= '0;
      pending_q <= '0;
    end else begin
      if (conflict) prio_q <= !prio_q;
      we_q <= fpu_wr || lsu_hs;
      unique case (1'b1)
        fpu_wr: begin
          waddr_q <= fpu_tag_i[4:0];
          wdata_q <= fpu_result_i;
        end
        lsu_hs: begin
          waddr_q <= lsu_rd_i;
          wdata_q <= lsu_data_i;
        end
        default: ;
      endcase
      if (fpu_hs && fpu_int) begin
        rv_q    <= 1'b1;
        rid_q   <= fpu_tag_i[4:0];
        rdata_q <= fpu_result_i[XLEN-1:0];
      end else if (acc_resp_ready_i) begin
        rv_q <= 1'b0;
      end
      fflags_q  <= fflags_d;
      pending_q <= (pending_q & ~pend_clr) | pend_set;
    end
  end

  assign fpr_we_o         = we_q;
  assign fpr_waddr_o      = waddr_q;
  assign fpr_wdata_o      = wdata_q;
  assign acc_resp_valid_o = rv_q;
  assign acc_resp_id_o    = rid_q;
  assign acc_resp_data_o  = rdata_q;
  assign fflags_o         = fflags_q;
  assign pending_o        = pending_q;

`ifdef SNITCH_FPU_WB_BYPASS_EN
  assign fwd_valid_o = we_q;
  assign fwd_addr_o  = waddr_q;
  assign fwd_data_o  = wdata_q;
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_addr_o  = '0;
  assign fwd_data_o  = '0;
`endif

`ifndef SYNTHESIS
  // Reissue to a register is fine only in the cycle its write retires.
  a_issue_free: assert property (@(posedge clk_i) disable iff (!rst_ni)
    issue_valid_i |->
      (!pending_q[issue_rd_i] || (we_q && waddr_q == issue_rd_i)));
  a_fpu_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fpu_valid_i && !fpu_ready_o) |=> fpu_valid_i);
`endif

endmodule

// File: tb/tb_snitch_fpu_wb.sv
// Directed bench for snitch_fpu_wb: vector table plus corner-case sequences.
module tb_snitch_fpu_wb;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic [63:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic [5:0]  fpu_tag_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [63:0] lsu_data_i;
  logic        fpr_we_o;
  logic [4:0]  fpr_waddr_o;
  logic [63:0] fpr_wdata_o;
  logic        acc_resp_valid_o;
  logic        acc_resp_ready_i;
  logic [4:0]  acc_resp_id_o;
  logic [31:0] acc_resp_data_o;
  logic        fflags_we_i;
  logic [4:0]  fflags_wdata_i;
  logic [4:0]  fflags_o;
  logic [31:0] pending_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [63:0] fwd_data_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  snitch_fpu_wb dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .fpu_tag_i(fpu_tag_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o),
    .fpr_wdata_o(fpr_wdata_o),
    .acc_resp_valid_o(acc_resp_valid_o),
    .acc_resp_ready_i(acc_resp_ready_i),
    .acc_resp_id_o(acc_resp_id_o), .acc_resp_data_o(acc_resp_data_o),
    .fflags_we_i(fflags_we_i), .fflags_wdata_i(fflags_wdata_i),
    .fflags_o(fflags_o), .pending_o(pending_o),
    .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o),
    .fwd_data_o(fwd_data_o)
  );

  typedef struct {
    logic        fv;
    logic [5:0]  tag;
    logic [63:0] res;
    logic        lv;
    logic [4:0]  lrd;
    logic [63:0] ld;
    logic        fr;
    logic        lr;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        rv;
    logic [4:0]  rid;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid_i    = 1'b0;
    issue_rd_i       = '0;
    fpu_valid_i      = 1'b0;
    fpu_result_i     = '0;
    fpu_status_i     = '0;
    fpu_tag_i        = '0;
    lsu_valid_i      = 1'b0;
    lsu_rd_i         = '0;
    lsu_data_i       = '0;
    acc_resp_ready_i = 1'b1;
    fflags_we_i      = 1'b0;
    fflags_wdata_i   = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [63:0] A = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] B = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] C = 64'hCCCC_0000_0000_0003;
  localparam logic [63:0] D = 64'hDDDD_0000_0000_0004;
  localparam logic [63:0] E = 64'hEEEE_0000_0000_0005;
  localparam logic [63:0] F = 64'hFFFF_0000_0000_0006;
  localparam logic [63:0] G = 64'h1111_0000_0000_0007;
  localparam logic [63:0] H = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] I = 64'h2222_0000_0000_0009;
  localparam logic [63:0] J = 64'h3333_0000_0000_000A;
  localparam logic [63:0] K = 64'h4444_0000_0000_000B;

  bit bypass_en;

  initial begin
`ifdef SNITCH_FPU_WB_BYPASS_EN
    bypass_en = 1'b1;
`else
    bypass_en = 1'b0;
`endif
    // fv tag res lv lrd ld | fr lr we wa wd rv rid rdat
    tbl[0] = '{1, 6'h01, A, 1, 5'd2,  B, 0, 1, 1, 5'd2,  B, 0, 0, 0};
    tbl[1] = '{1, 6'h01, A, 1, 5'd2,  C, 1, 0, 1, 5'd1,  A, 0, 0, 0};
    tbl[2] = '{1, 6'h01, D, 1, 5'd2,  C, 0, 1, 1, 5'd2,  C, 0, 0, 0};
    tbl[3] = '{1, 6'h01, D, 1, 5'd2,  E, 1, 0, 1, 5'd1,  D, 0, 0, 0};
    tbl[4] = '{1, 6'h04, F, 0, 5'd0,  0, 1, 1, 1, 5'd4,  F, 0, 0, 0};
    tbl[5] = '{0, 6'h00, 0, 1, 5'd9,  G, 1, 1, 1, 5'd9,  G, 0, 0, 0};
    tbl[6] = '{1, 6'h26, H, 1, 5'd10, I, 1, 1, 1, 5'd10, I, 1, 5'd6,
               32'h9ABC_DEF0};
    tbl[7] = '{0, 6'h00, 0, 0, 5'd0,  0, 1, 1, 0, 5'd0,  0, 0, 0, 0};
    tbl[8] = '{1, 6'h05, J, 1, 5'd11, K, 0, 1, 1, 5'd11, K, 0, 0, 0};
    tbl[9] = '{1, 6'h05, J, 0, 5'd0,  0, 1, 1, 1, 5'd5,  J, 0, 0, 0};

    // Reset held across an active FPU handshake
    idle();
    rst_ni       = 1'b0;
    fpu_valid_i  = 1'b1;
    fpu_tag_i    = 6'h03;
    fpu_result_i = A;
    fpu_status_i = 5'h1f;
    issue_valid_i = 1'b1;
    issue_rd_i   = 5'd3;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_we", fpr_we_o, 0);
      chk("rst_wdata", fpr_wdata_o, 0);
      chk("rst_rv", acc_resp_valid_o, 0);
      chk("rst_pending", pending_o, 0);
      chk("rst_fflags", fflags_o, 0);
      chk("rst_fpu_ready", fpu_ready_o, 0);
      chk("rst_lsu_ready", lsu_ready_o, 0);
      chk("rst_fwd", fwd_valid_o, 0);
    end
    idle();
    rst_ni = 1'b1;
    tick();
    chk("post_rst_we", fpr_we_o, 0);
    chk("post_rst_pending", pending_o, 0);
    chk("post_rst_fflags", fflags_o, 0);

    // FP write with scoreboard
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd3;
    tick();
    issue_valid_i = 1'b0;
    chk("sb_set3", pending_o[3], 1);
    fpu_valid_i  = 1'b1;
    fpu_tag_i    = 6'h03;
    fpu_result_i = 64'h4000_0000_0000_0000;
    #1;
    chk("fp_ready", fpu_ready_o, 1);
    tick();
    idle();
    chk("fp_we", fpr_we_o, 1);
    chk("fp_waddr", fpr_waddr_o, 3);
    chk("fp_wdata", fpr_wdata_o, 64'h4000_0000_0000_0000);
    chk("fp_pend_hold", pending_o[3], 1);
    chk("fp_fwd_valid", fwd_valid_o, bypass_en);
    chk("fp_fwd_addr", fwd_addr_o, bypass_en ? 3 : 0);
    tick();
    chk("fp_we_once", fpr_we_o, 0);
    chk("sb_clr3", pending_o[3], 0);

    // Vector table: contention, single requesters, dual accept
    foreach (tbl[i]) begin
      fpu_valid_i  = tbl[i].fv;
      fpu_tag_i    = tbl[i].tag;
      fpu_result_i = tbl[i].res;
      lsu_valid_i  = tbl[i].lv;
      lsu_rd_i     = tbl[i].lrd;
      lsu_data_i   = tbl[i].ld;
      #1;
      chk($sformatf("v%0d_fpu_ready", i), fpu_ready_o, tbl[i].fr);
      chk($sformatf("v%0d_lsu_ready", i), lsu_ready_o, tbl[i].lr);
      tick();
      chk($sformatf("v%0d_we", i), fpr_we_o, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("v%0d_waddr", i), fpr_waddr_o, tbl[i].wa);
        chk($sformatf("v%0d_wdata", i), fpr_wdata_o, tbl[i].wd);
      end
      chk($sformatf("v%0d_rv", i), acc_resp_valid_o, tbl[i].rv);
      if (tbl[i].rv) begin
        chk($sformatf("v%0d_rid", i), acc_resp_id_o, tbl[i].rid);
        chk($sformatf("v%0d_rdata", i), acc_resp_data_o, tbl[i].rdat);
      end
    end
    idle();
    tick();

    // Integer response under backpressure
    acc_resp_ready_i = 1'b0;
    fpu_valid_i  = 1'b1;
    fpu_tag_i    = 6'h25;
    fpu_result_i = 64'h0123_4567_DEAD_BEEF;
    #1;
    chk("int_ready0", fpu_ready_o, 1);
    tick();
    fpu_tag_i    = 6'h28;
    fpu_result_i = 64'h7654_3210_CAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("int_stall_ready", fpu_ready_o, 0);
      chk("int_hold_valid", acc_resp_valid_o, 1);
      chk("int_hold_id", acc_resp_id_o, 5);
      chk("int_hold_data", acc_resp_data_o, 32'hDEAD_BEEF);
      tick();
    end
    acc_resp_ready_i = 1'b1;
    #1;
    chk("int_drain_ready", fpu_ready_o, 1);
    tick();
    fpu_valid_i = 1'b0;
    chk("int2_valid", acc_resp_valid_o, 1);
    chk("int2_id", acc_resp_id_o, 8);
    chk("int2_data", acc_resp_data_o, 32'hCAFE_F00D);
    tick();
    chk("int_empty", acc_resp_valid_o, 0);

    // Sticky fflags
    idle();
    fpu_valid_i  = 1'b1;
    fpu_tag_i    = 6'h0c;
    fpu_status_i = 5'h01;
    tick();
    chk("ff_first", fflags_o, 5'h01);
    fpu_tag_i    = 6'h2c;
    fpu_status_i = 5'h10;
    tick();
    chk("ff_accum", fflags_o, 5'h11);
    fpu_tag_i      = 6'h0d;
    fpu_status_i   = 5'h04;
    fflags_we_i    = 1'b1;
    fflags_wdata_i = 5'h00;
    tick();
    idle();
    chk("ff_csr_write", fflags_o, 5'h04);
    tick();
    chk("ff_sticky", fflags_o, 5'h04);

    // Scoreboard set/clear collision
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd7;
    tick();
    issue_valid_i = 1'b0;
    chk("sb_set7", pending_o[7], 1);
    fpu_valid_i = 1'b1;
    fpu_tag_i   = 6'h07;
    fpu_result_i = G;
    tick();
    idle();
    chk("col_we", fpr_we_o, 1);
    chk("col_waddr", fpr_waddr_o, 7);
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd7;
    tick();
    idle();
    chk("col_pend7", pending_o[7], 1);
    tick();
    chk("col_pend7_hold", pending_o[7], 1);
    chk("col_no_we", fpr_we_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
